// File: rtl/fifo_sequencer.sv
// fifo_sequencer: control FSM for the 31-symbol received-word FIFO of the RS decoder.
// The FSM loads a codeword, holds it while the decode stages run, then shifts it out
// symbol-aligned with the error-evaluation stream.
// Optional feature: define FIFO_SEQ_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT cycles.
`timescale 1ns/1ps
module fifo_sequencer #(
  parameter int N_SYM   = 31,
  parameter int CNT_W   = 5
`ifdef FIFO_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             out_start,
  output logic             shift_fifo,
  output logic             hold_fifo,
  output logic             en_infifo,
  output logic             en_outfifo,
  output logic             busy,
  output logic [CNT_W-1:0] sym_index,
  output logic             load_done,
  output logic             unload_done,
  output logic             err_sof,
  output logic             timeout
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_UNLOAD} state_t;

  localparam logic [CNT_W-1:0] LAST_SYM = CNT_W'(N_SYM - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_load_done, w_load_done_nxt;
  logic             r_unload_done, w_unload_done_nxt;
  logic             r_err_sof, w_err_sof_nxt;
  logic             w_shift;
  logic             w_en_in;
  logic             w_en_out;

`ifdef FIFO_SEQ_TIMEOUT_EN
  logic [7:0] r_wait_cnt, w_wait_cnt_nxt;
  logic       r_timeout, w_timeout_nxt;
`endif

  // State, symbol counter and event-pulse registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_load_done   <= 1'b0;
      r_unload_done <= 1'b0;
      r_err_sof     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_load_done   <= w_load_done_nxt;
      r_unload_done <= w_unload_done_nxt;
      r_err_sof     <= w_err_sof_nxt;
    end
  end

`ifdef FIFO_SEQ_TIMEOUT_EN
  // WAIT-duration counter and abort pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end
`endif

  // Next-state decode plus zero-latency FIFO controls from state and inputs.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_load_done_nxt   = 1'b0;
    w_unload_done_nxt = 1'b0;
    w_err_sof_nxt     = 1'b0;
    w_shift           = 1'b0;
    w_en_in           = 1'b0;
    w_en_out          = 1'b0;
`ifdef FIFO_SEQ_TIMEOUT_EN
    w_wait_cnt_nxt    = r_wait_cnt;
    w_timeout_nxt     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        // Reset is folded in so a sof present during reset never drives a shift.
        if (reset && in_valid && in_sof) begin
          w_shift     = 1'b1;
          w_en_in     = 1'b1;
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          w_shift = 1'b1;
          w_en_in = 1'b1;
          if (in_sof && (r_cnt != '0)) begin
            // Restart: this symbol becomes symbol 0; stale ones shift out later.
            w_err_sof_nxt = 1'b1;
            w_cnt_nxt     = CNT_W'(1);
          end else if (r_cnt == LAST_SYM) begin
            w_state_nxt     = S_WAIT;
            w_cnt_nxt       = '0;
            w_load_done_nxt = 1'b1;
`ifdef FIFO_SEQ_TIMEOUT_EN
            w_wait_cnt_nxt  = '0;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (out_start) begin
          w_state_nxt = S_UNLOAD;
          w_cnt_nxt   = '0;
        end
`ifdef FIFO_SEQ_TIMEOUT_EN
        else if (r_wait_cnt == 8'(TIMEOUT - 1)) begin
          w_state_nxt   = S_IDLE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 8'd1;
        end
`endif
      end
      S_UNLOAD: begin
        // Zero-fill input while the stored word drains through the output register.
        w_shift  = 1'b1;
        w_en_out = 1'b1;
        if (r_cnt == LAST_SYM) begin
          w_state_nxt       = S_IDLE;
          w_cnt_nxt         = '0;
          w_unload_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign shift_fifo  = w_shift;
  assign hold_fifo   = ~w_shift;
  assign en_infifo   = w_en_in;
  assign en_outfifo  = w_en_out;
  assign busy        = (r_state != S_IDLE);
  assign sym_index   = ((r_state == S_LOAD) || (r_state == S_UNLOAD)) ? r_cnt : '0;
  assign load_done   = r_load_done;
  assign unload_done = r_unload_done;
  assign err_sof     = r_err_sof;
`ifdef FIFO_SEQ_TIMEOUT_EN
  assign timeout     = r_timeout;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sequencer.sv
// Self-checking bench for fifo_sequencer: a table of single-cycle vectors, then
// hand-written load/stall/restart/unload/reset sequences, all compared each cycle
// through an expected-output queue.
`timescale 1ns/1ps
module tb_fifo_sequencer;

  logic       clock;
  logic       reset;
  logic       in_valid, in_sof, out_start;
  logic       shift_fifo, hold_fifo, en_infifo, en_outfifo, busy;
  logic [4:0] sym_index;
  logic       load_done, unload_done, err_sof, timeout;

  fifo_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .out_start   (out_start),
    .shift_fifo  (shift_fifo),
    .hold_fifo   (hold_fifo),
    .en_infifo   (en_infifo),
    .en_outfifo  (en_outfifo),
    .busy        (busy),
    .sym_index   (sym_index),
    .load_done   (load_done),
    .unload_done (unload_done),
    .err_sof     (err_sof),
    .timeout     (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       shift;
    logic       hold;
    logic       en_in;
    logic       en_out;
    logic       busy;
    logic [4:0] idx;
    logic       ld;
    logic       ud;
    logic       es;
    logic       to;
  } out_t;

  typedef struct {
    logic  v;
    logic  s;
    logic  o;
    out_t  exp;
    string name;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  out_t exp_q[$];

  function automatic out_t mk(input logic sh, input logic en_i, input logic en_o,
                              input logic bz, input int idx, input logic ld,
                              input logic ud, input logic es, input logic to);
    out_t r;
    r.shift  = sh;
    r.hold   = ~sh;
    r.en_in  = en_i;
    r.en_out = en_o;
    r.busy   = bz;
    r.idx    = 5'(idx);
    r.ld     = ld;
    r.ud     = ud;
    r.es     = es;
    r.to     = to;
    return r;
  endfunction

  function automatic out_t idle_o(input logic accept, input logic ud, input logic to);
    return mk(accept, accept, 1'b0, 1'b0, 0, 1'b0, ud, 1'b0, to);
  endfunction

  function automatic out_t load_o(input logic sh, input int idx, input logic es);
    return mk(sh, sh, 1'b0, 1'b1, idx, 1'b0, 1'b0, es, 1'b0);
  endfunction

  function automatic out_t wait_o(input logic ld);
    return mk(1'b0, 1'b0, 1'b0, 1'b1, 0, ld, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic out_t unload_o(input int k);
    return mk(1'b1, 1'b0, 1'b1, 1'b1, k, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic out_t sample();
    out_t a;
    a.shift  = shift_fifo;
    a.hold   = hold_fifo;
    a.en_in  = en_infifo;
    a.en_out = en_outfifo;
    a.busy   = busy;
    a.idx    = sym_index;
    a.ld     = load_done;
    a.ud     = unload_done;
    a.es     = err_sof;
    a.to     = timeout;
    return a;
  endfunction

  // Field order in the printed hex: shift,hold,en_in,en_out,busy,idx[4:0],ld,ud,es,to.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs after the edge, queue the expectation, compare on the falling edge.
  task automatic step(input logic v, input logic s, input logic o,
                      input out_t exp, input string name);
    out_t e;
    @(posedge clock);
    #1;
    in_valid  = v;
    in_sof    = s;
    out_start = o;
    exp_q.push_back(exp);
    @(negedge clock);
    e = exp_q.pop_front();
    check(name, {18'd0, sample()}, {18'd0, e});
  endtask

  task automatic unload_word(input string tag);
    for (int k = 0; k < 31; k++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           unload_o(k), $sformatf("%s_unload%0d", tag, k));
    step(1'b0, 1'b0, 1'b0, idle_o(1'b0, 1'b1, 1'b0), {tag, "_unload_done"});
  endtask

  vec_t vecs[8];
  out_t rst_o;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_o     = idle_o(1'b0, 1'b0, 1'b0);
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_start = 1'b0;
    #1;
    check("reset_values", {18'd0, sample()}, {18'd0, rst_o});
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // Single-cycle behaviour in IDLE and the first few LOAD cycles.
    vecs[0] = '{1'b0, 1'b0, 1'b0, idle_o(1'b0, 1'b0, 1'b0), "idle_quiet"};
    vecs[1] = '{1'b1, 1'b0, 1'b0, idle_o(1'b0, 1'b0, 1'b0), "idle_valid_no_sof"};
    vecs[2] = '{1'b0, 1'b1, 1'b0, idle_o(1'b0, 1'b0, 1'b0), "idle_sof_no_valid"};
    vecs[3] = '{1'b0, 1'b0, 1'b1, idle_o(1'b0, 1'b0, 1'b0), "idle_out_start"};
    vecs[4] = '{1'b1, 1'b1, 1'b0, idle_o(1'b1, 1'b0, 1'b0), "idle_accept_sym0"};
    vecs[5] = '{1'b1, 1'b0, 1'b0, load_o(1'b1, 1, 1'b0),    "load_sym1"};
    vecs[6] = '{1'b0, 1'b0, 1'b0, load_o(1'b0, 2, 1'b0),    "load_stall"};
    vecs[7] = '{1'b1, 1'b0, 1'b0, load_o(1'b1, 2, 1'b0),    "load_sym2"};
    for (int i = 0; i < 8; i++)
      step(vecs[i].v, vecs[i].s, vecs[i].o, vecs[i].exp, vecs[i].name);

    // Back-to-back load to WAIT, then unload.
    for (int i = 3; i < 31; i++)
      step(1'b1, 1'b0, 1'b0, load_o(1'b1, i, 1'b0), $sformatf("t1_load%0d", i));
    step(1'b0, 1'b0, 1'b0, wait_o(1'b1), "t1_load_done");
    step(1'b1, 1'b1, 1'b0, wait_o(1'b0), "t1_wait_ignores_sof");
    step(1'b0, 1'b0, 1'b1, wait_o(1'b0), "t1_out_start");
    unload_word("t1");
    step(1'b0, 1'b0, 1'b0, idle_o(1'b0, 1'b0, 1'b0), "t1_idle_after");

    // Load with stalls on symbols 10-14; out_start in the last LOAD cycle is ignored.
    step(1'b1, 1'b1, 1'b0, idle_o(1'b1, 1'b0, 1'b0), "t2_sym0");
    for (int i = 1; i < 10; i++)
      step(1'b1, 1'b0, 1'b0, load_o(1'b1, i, 1'b0), $sformatf("t2_load%0d", i));
    for (int j = 0; j < 5; j++)
      step(1'b0, 1'b0, 1'b0, load_o(1'b0, 10, 1'b0), $sformatf("t2_stall%0d", j));
    for (int i = 10; i < 31; i++)
      step(1'b1, 1'b0, (i == 30), load_o(1'b1, i, 1'b0), $sformatf("t2_load%0d", i));
    step(1'b0, 1'b0, 1'b0, wait_o(1'b1), "t2_load_done_no_unload");
    step(1'b0, 1'b0, 1'b0, wait_o(1'b0), "t2_wait_hold");
    step(1'b0, 1'b0, 1'b1, wait_o(1'b0), "t2_out_start");
    for (int k = 0; k <= 12; k++)
      step(1'b0, 1'b0, 1'b0, unload_o(k), $sformatf("t2_unload%0d", k));

    // Asynchronous reset during UNLOAD at count 12.
    #1 reset = 1'b0;
    #1;
    check("t5_reset_immediate", {18'd0, sample()}, {18'd0, rst_o});
    @(posedge clock);
    #2;
    check("t5_reset_held", {18'd0, sample()}, {18'd0, rst_o});
    reset = 1'b1;

    // New word after reset, restarted by a sof at symbol 17.
    step(1'b1, 1'b1, 1'b0, idle_o(1'b1, 1'b0, 1'b0), "t3_sym0_after_reset");
    for (int i = 1; i < 17; i++)
      step(1'b1, 1'b0, 1'b0, load_o(1'b1, i, 1'b0), $sformatf("t3_load%0d", i));
    step(1'b1, 1'b1, 1'b0, load_o(1'b1, 17, 1'b0), "t3_sof_mid_load");
    step(1'b1, 1'b0, 1'b0, load_o(1'b1, 1, 1'b1), "t3_err_sof_restart");
    for (int i = 2; i < 31; i++)
      step(1'b1, 1'b0, 1'b0, load_o(1'b1, i, 1'b0), $sformatf("t3_reload%0d", i));
    step(1'b0, 1'b0, 1'b0, wait_o(1'b1), "t3_load_done");

`ifdef FIFO_SEQ_TIMEOUT_EN
    // WAIT without out_start aborts 255 cycles after WAIT entry.
    for (int w = 1; w < 255; w++)
      step(1'b0, 1'b0, 1'b0, wait_o(1'b0), $sformatf("t6_wait%0d", w));
    step(1'b0, 1'b0, 1'b0, idle_o(1'b0, 1'b0, 1'b1), "t6_timeout_pulse");
    step(1'b0, 1'b0, 1'b0, idle_o(1'b0, 1'b0, 1'b0), "t6_idle_after");
`else
    // WAIT persists indefinitely without out_start.
    for (int w = 1; w < 300; w++)
      step(1'b0, 1'b0, 1'b0, wait_o(1'b0), $sformatf("t6_wait%0d", w));
    step(1'b0, 1'b0, 1'b1, wait_o(1'b0), "t3_out_start");
    unload_word("t3");
`endif
    step(1'b0, 1'b0, 1'b0, idle_o(1'b0, 1'b0, 1'b0), "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
